lcd1602_ctrl: RTL
=================

Name: lcd1602_ctrl

Overview:
- Sequencer for an HD44780-compatible LCD1602 on an 8-bit parallel bus.
- After reset it waits for LCD power-up, then issues a fixed init sequence.
- It then accepts command/data bytes from upstream logic over a valid/ready handshake.
- Each byte gets a properly timed E pulse and the required execution wait, so upstream never deals with LCD timing.

Parameters:
- PWRUP_CYC, 750000: cycles to wait after reset before the first write (15 ms @ 50 MHz).
- SETUP_CYC, 4: cycles RS/DAT are stable before E rises (min 1).
- PULSE_CYC, 25: cycles E is high (min 1).
- HOLD_CYC, 4: cycles RS/DAT are held after E falls (min 1).
- EXEC_CYC, 2500: post-write wait for normal commands and data (50 us).
- CLEAR_CYC, 100000: post-write wait for clear/home commands 0x01, 0x02, 0x03 (2 ms).
- CNT_W, 24: width of the shared timing counter; must hold the largest *_CYC value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a byte
- in_rs  in  1  0 = command, 1 = data
- in_data  in  8  byte to write
- in_ready  out  1  block accepts a byte this cycle
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW, tied 0 (write-only)
- lcd_en  out  1  LCD E
- lcd_dat  out  8  LCD DB7..DB0
- init_done  out  1  init sequence complete
- busy  out  1  engine not in IDLE

Behaviour:
- Reset values: lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_dat=8'h00, in_ready=0, init_done=0, busy=1.
- States:
  - PWRUP: count PWRUP_CYC, then go to INIT.
  - INIT: load the next ROM entry, then go to SETUP.
  - SETUP: SETUP_CYC cycles, then PULSE.
  - PULSE: SETUP_CYC is done; lcd_en=1 for PULSE_CYC cycles, then HOLD.
  - HOLD: lcd_en=0 for HOLD_CYC cycles, then EXEC.
  - EXEC: wait CLEAR_CYC if (rs=0 and byte in {01,02,03}), else EXEC_CYC. Then go to INIT if ROM entries remain, else IDLE.
  - IDLE: in_ready=1.
- Init ROM, all rs=0, in order: 0x38, 0x0C, 0x06, 0x01. init_done rises on entry to IDLE after the 4th entry and stays 1 until rst.
- Handshake:
  - A byte is accepted on the cycle where in_valid && in_ready (cycle T). rs/data are latched at T.
  - in_ready=0 from T+1.
  - lcd_rs/lcd_dat take the latched values at T+1 and hold them until the next write starts.
  - lcd_en rises at T+1+SETUP_CYC and falls at T+1+SETUP_CYC+PULSE_CYC.
  - in_ready returns 1 exactly SETUP_CYC+PULSE_CYC+HOLD_CYC+wait cycles after T+1.
  - in_ready is never 1 before init_done.
  - in_valid while not ready is ignored; nothing is queued.
- busy = (state != IDLE).
- Timing counter:
  - One CNT_W-bit down-counter, reloaded on each state entry; a state exits when the counter reaches 1.
  - It never wraps. A parameter of 0 is illegal and is treated as 1.
- rst asserted mid-write:
  - Next cycle returns to reset values with lcd_en=0, even if the byte was mid-PULSE.
  - The latched byte is discarded, the full PWRUP and INIT sequence reruns, and init_done falls to 0.
- lcd_dat/lcd_rs only change while lcd_en=0. No glitches on lcd_en; it is registered.

Optional Feature:
- LCD1602_CURSOR_TRACK_EN defined: the block keeps a 5-bit column counter col (0..31).
  - Reset/init sets col=0.
  - An accepted data byte increments col after its EXEC.
  - If col becomes 16, the engine auto-inserts command 0xC0 (SETUP/PULSE/HOLD/EXEC) before in_ready reasserts.
  - If col becomes 32, it inserts 0x80 and sets col=0.
  - Command 0x01/0x02/0x03 sets col=0.
  - A command with bit7=1 sets col = {addr[6], addr[3:0]}.
- LCD1602_CURSOR_TRACK_EN undefined: no column tracking and no inserted commands. Every byte is written verbatim.

Test Plan:
- Sim parameters: PWRUP=100, SETUP=2, PULSE=4, HOLD=2, EXEC=10, CLEAR=50.
- Reset then idle -> no lcd_en for 100 cycles. Then exactly 4 E pulses carrying 38, 0C, 06, 01 with rs=0. Gap after 01 is 50 cycles; init_done=1, in_ready=1.
- Send data 0x48 rs=1 at cycle T -> lcd_dat=48 and lcd_rs=1 at T+1; lcd_en high T+3..T+6; in_ready=1 at T+1+18.
- Send command 0x01 -> in_ready returns 58 cycles after T+1.
- Hold in_valid=1 continuously with varying data -> each byte accepted only when in_ready=1, none dropped or duplicated. Check E-pulse count equals accepted count.
- Assert rst during PULSE -> lcd_en=0 next cycle, init_done=0, full init sequence repeats.
- With LCD1602_CURSOR_TRACK_EN, write 16 data bytes -> an extra E pulse with rs=0, dat=0xC0 follows the 16th. Without the macro, no extra pulse.

Source files
------------

// File: rtl/lcd1602_ctrl.sv
// HD44780/LCD1602 8-bit write sequencer: power-up wait, fixed init ROM, then timed upstream writes.
// Optional column tracking with auto line-wrap commands when LCD1602_CURSOR_TRACK_EN is defined.
module lcd1602_ctrl #(
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned PULSE_CYC = 25,
    parameter int unsigned HOLD_CYC  = 4,
    parameter int unsigned EXEC_CYC  = 2500,
    parameter int unsigned CLEAR_CYC = 100000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       rom_idx_q;
    logic             en_q, rs_q, ready_q, done_q, busy_q;
    logic [7:0]       dat_q;

    logic             cnt_last;
    logic             clear_cmd;
    logic [CNT_W-1:0] exec_ld;

    // A zero-cycle parameter still spends one cycle in its state.
    function automatic logic [CNT_W-1:0] cyc_ld(input int unsigned c);
        return (c == 0) ? CNT_W'(1) : CNT_W'(c);
    endfunction

    function automatic logic [7:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    always_comb begin
        cnt_last  = (cnt_q <= CNT_W'(1));
        clear_cmd = !rs_q && (dat_q == 8'h01 || dat_q == 8'h02 || dat_q == 8'h03);
        exec_ld   = clear_cmd ? cyc_ld(CLEAR_CYC) : cyc_ld(EXEC_CYC);
    end

`ifdef LCD1602_CURSOR_TRACK_EN
    logic [4:0] col_q, col_d;
    logic       ins_d;
    logic [7:0] ins_dat_d;
    logic [5:0] col_nxt;

    // Column effect of the byte just executed; line ends force a DDRAM address command.
    always_comb begin
        col_nxt   = {1'b0, col_q} + 6'd1;
        col_d     = col_q;
        ins_d     = 1'b0;
        ins_dat_d = 8'h00;
        if (rs_q) begin
            if (col_nxt == 6'd16) begin
                col_d     = 5'd16;
                ins_d     = 1'b1;
                ins_dat_d = 8'hC0;
            end else if (col_nxt == 6'd32) begin
                col_d     = 5'd0;
                ins_d     = 1'b1;
                ins_dat_d = 8'h80;
            end else begin
                col_d = col_nxt[4:0];
            end
        end else if (clear_cmd) begin
            col_d = 5'd0;
        end else if (dat_q[7]) begin
            col_d = {dat_q[6], dat_q[3:0]};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PWRUP;
            cnt_q     <= cyc_ld(PWRUP_CYC);
            rom_idx_q <= '0;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            dat_q     <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
`ifdef LCD1602_CURSOR_TRACK_EN
            col_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                S_PWRUP: begin
                    if (cnt_last) state_q <= S_INIT;
                    else          cnt_q   <= cnt_q - CNT_W'(1);
                end
                S_INIT: begin
                    rs_q      <= 1'b0;
                    dat_q     <= rom(rom_idx_q);
                    rom_idx_q <= rom_idx_q + 3'd1;
                    cnt_q     <= cyc_ld(SETUP_CYC);
                    state_q   <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt_last) begin
                        en_q    <= 1'b1;
                        cnt_q   <= cyc_ld(PULSE_CYC);
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_last) begin
                        en_q    <= 1'b0;
                        cnt_q   <= cyc_ld(HOLD_CYC);
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_last) begin
                        cnt_q   <= exec_ld;
                        state_q <= S_EXEC;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (cnt_last) begin
`ifdef LCD1602_CURSOR_TRACK_EN
                        col_q <= col_d;
`endif
                        if (rom_idx_q != 3'd4) begin
                            state_q <= S_INIT;
                        end
`ifdef LCD1602_CURSOR_TRACK_EN
                        else if (ins_d) begin
                            rs_q    <= 1'b0;
                            dat_q   <= ins_dat_d;
                            cnt_q   <= cyc_ld(SETUP_CYC);
                            state_q <= S_SETUP;
                        end
`endif
                        else begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        rs_q    <= in_rs;
                        dat_q   <= in_data;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= cyc_ld(SETUP_CYC);
                        state_q <= S_SETUP;
                    end
                end
                default: state_q <= S_PWRUP;
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;
    assign lcd_dat   = dat_q;
    assign init_done = done_q;
    assign busy      = busy_q;

endmodule
